i2c_scl_gen: RTL and testbench

- SCL timing generator for the I2C test master.
- Divides `clk` into quarter-bit phases, drives the open-drain SCL enable, and honours slave clock stretching.
- Emits a one-cycle `q_tick` per quarter phase. `q_tick` feeds the `en` input of the downstream bit/quarter counter and the bit-level shifter.

---
 rtl/i2c_scl_gen.sv | 147 ++++++++++++++
 tb/tb_i2c_scl_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// Quarter-phase SCL generator for the I2C test master, with slave clock stretching.
// Optional stretch timeout is compiled in with `define STRETCH_TIMEOUT_EN.
module i2c_scl_gen #(
    parameter int DIV_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 scl_in,
    output logic                 scl_oe,
    output logic                 q_tick,
    output logic [1:0]           phase,
    output logic                 bit_done,
    output logic                 busy,
    output logic                 stretch,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STRETCH = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(3);

    state_t               state_reg;
    logic [DIV_WIDTH-1:0] div_cnt_reg;
    logic [DIV_WIDTH-1:0] div_eff_reg;
    logic [1:0]           phase_reg;
    logic                 scl_oe_reg;
    logic                 sync1_reg;
    logic                 sync2_reg;

    logic                 scl_s;
    logic [DIV_WIDTH-1:0] div_clamped;
    logic                 terminal;
    logic                 stretch_hit;
    logic                 release_hit;
    logic                 timeout_hit;

    assign scl_s       = sync2_reg;
    assign div_clamped = (div < DIV_MIN) ? DIV_MIN : div;
    assign terminal    = (state_reg == RUN) && (div_cnt_reg == div_eff_reg - DIV_WIDTH'(1));
    // Slave still holding SCL low at the end of the high-going phase 2.
    assign stretch_hit = terminal && (phase_reg == 2'd2) && !scl_s;
    assign release_hit = (state_reg == STRETCH) && scl_s;

    assign q_tick   = (terminal && !stretch_hit) || release_hit;
    assign bit_done = terminal && (phase_reg == 2'd3);
    assign scl_oe   = scl_oe_reg;
    assign phase    = phase_reg;
    assign busy     = (state_reg != IDLE);
    assign stretch  = (state_reg == STRETCH);

`ifdef STRETCH_TIMEOUT_EN
    logic [31:0] stretch_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stretch_cnt_reg <= '0;
        end else if (state_reg != STRETCH) begin
            stretch_cnt_reg <= '0;
        end else begin
            stretch_cnt_reg <= stretch_cnt_reg + 32'd1;
        end
    end

    // A release seen in the limit cycle takes priority over the timeout.
    assign timeout_hit = (state_reg == STRETCH) && !scl_s &&
                         (stretch_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
    // Parameter stays referenced so both builds share one interface.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    assign timeout = timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            div_eff_reg <= DIV_MIN;
            phase_reg   <= 2'd0;
            scl_oe_reg  <= 1'b0;
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
        end else begin
            sync1_reg <= scl_in;
            sync2_reg <= sync1_reg;
            case (state_reg)
                IDLE: begin
                    scl_oe_reg <= 1'b0;
                    if (en) begin
                        state_reg   <= RUN;
                        div_cnt_reg <= '0;
                        phase_reg   <= 2'd0;
                        scl_oe_reg  <= 1'b1;
                        div_eff_reg <= div_clamped;
                    end
                end
                RUN: begin
                    if (stretch_hit) begin
                        state_reg <= STRETCH;
                    end else if (terminal) begin
                        div_cnt_reg <= '0;
                        if (phase_reg == 2'd3) begin
                            phase_reg <= 2'd0;
                            if (en) begin
                                scl_oe_reg  <= 1'b1;
                                div_eff_reg <= div_clamped;
                            end else begin
                                state_reg  <= IDLE;
                                scl_oe_reg <= 1'b0;
                            end
                        end else begin
                            phase_reg  <= phase_reg + 2'd1;
                            // Low for phases 0-1, released for phases 2-3.
                            scl_oe_reg <= (phase_reg == 2'd0);
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_WIDTH'(1);
                    end
                end
                STRETCH: begin
                    scl_oe_reg <= 1'b0;
                    if (release_hit) begin
                        state_reg   <= RUN;
                        phase_reg   <= 2'd3;
                        div_cnt_reg <= '0;
                    end else if (timeout_hit) begin
                        state_reg   <= IDLE;
                        phase_reg   <= 2'd0;
                        div_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    scl_oe_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Scoreboard bench for i2c_scl_gen: expected q_tick events are queued per scenario
// and matched by a negedge monitor; scenario tasks also check levels inline.
module tb_i2c_scl_gen;

    localparam int DW = 16;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [DW-1:0] div = 16'd4;
    logic          hold = 1'b0;
    logic          scl_in;
    logic          scl_oe;
    logic          q_tick;
    logic [1:0]    phase;
    logic          bit_done;
    logic          busy;
    logic          stretch;
    logic          timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [1:0] ph;
        logic       bd;
    } exp_t;

    exp_t sb[$];

    // Open-drain bus: low if the master drives or the slave holds.
    assign scl_in = !(scl_oe | hold);

    i2c_scl_gen #(.DIV_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .scl_in(scl_in),
        .scl_oe(scl_oe), .q_tick(q_tick), .phase(phase), .bit_done(bit_done),
        .busy(busy), .stretch(stretch), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (q_tick) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick cyc=%0d phase=%0d bit_done=%0b", cyc, phase, bit_done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc || phase !== e.ph || bit_done !== e.bd) begin
                    errors++;
                    $display("FAIL tick got cyc=%0d phase=%0d bit_done=%0b expected cyc=%0d phase=%0d bit_done=%0b",
                             cyc, phase, bit_done, e.cyc, e.ph, e.bd);
                end
            end
        end else if (bit_done) begin
            checks++;
            errors++;
            $display("FAIL bit_done_without_tick cyc=%0d got 1 expected 0", cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bit of n ticks starting with phase 0; base is the cycle en is first seen.
    task automatic push_ticks(input int base, input int d, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.cyc = base + d * (k + 1);
            e.ph  = 2'(k % 4);
            e.bd  = ((k % 4) == 3);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        goto(cyc + 3);
        checks += 7;
        if (scl_oe !== 1'b0)   begin errors++; $display("FAIL reset_scl_oe got %0b expected 0", scl_oe); end
        if (q_tick !== 1'b0)   begin errors++; $display("FAIL reset_q_tick got %0b expected 0", q_tick); end
        if (bit_done !== 1'b0) begin errors++; $display("FAIL reset_bit_done got %0b expected 0", bit_done); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
        if (stretch !== 1'b0)  begin errors++; $display("FAIL reset_stretch got %0b expected 0", stretch); end
        if (timeout !== 1'b0)  begin errors++; $display("FAIL reset_timeout got %0b expected 0", timeout); end
        if (phase !== 2'd0)    begin errors++; $display("FAIL reset_phase got %0d expected 0", phase); end
        rst = 1'b0;
        goto(cyc + 2);
    endtask

    task automatic test_basic_and_stop();
        int a;
        logic       exp_oe;
        logic [1:0] exp_ph;
        div = 16'd4;
        goto(cyc + 1);
        a = cyc;
        push_ticks(a, 4, 8);
        en = 1'b1;
        for (int r = 1; r <= 32; r++) begin
            goto(a + r);
            exp_oe = (((r - 1) % 16) < 8);
            exp_ph = 2'(((r - 1) / 4) % 4);
            checks += 3;
            if (scl_oe !== exp_oe) begin errors++; $display("FAIL basic_scl_oe r=%0d got %0b expected %0b", r, scl_oe, exp_oe); end
            if (phase !== exp_ph)  begin errors++; $display("FAIL basic_phase r=%0d got %0d expected %0d", r, phase, exp_ph); end
            if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy r=%0d got %0b expected 1", r, busy); end
            if (r == 22) en = 1'b0;
        end
        goto(a + 33);
        checks += 2;
        if (busy !== 1'b0)   begin errors++; $display("FAIL stop_busy got %0b expected 0", busy); end
        if (scl_oe !== 1'b0) begin errors++; $display("FAIL stop_scl_oe got %0b expected 0", scl_oe); end
        goto(a + 45);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL basic_pending got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_clamp();
        int a;
        for (int i = 0; i < 2; i++) begin
            div = DW'(i);
            goto(cyc + 1);
            a = cyc;
            push_ticks(a, 3, 4);
            en = 1'b1;
            goto(a + 1);
            en = 1'b0;
            checks++;
            if (scl_oe !== 1'b1) begin errors++; $display("FAIL clamp_scl_oe div=%0d got %0b expected 1", i, scl_oe); end
            goto(a + 13);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL clamp_busy div=%0d got %0b expected 0", i, busy); end
            goto(a + 18);
            checks++;
            if (sb.size() !== 0) begin errors++; $display("FAIL clamp_pending div=%0d got %0d expected 0", i, sb.size()); sb.delete(); end
        end
    endtask

    task automatic test_div_change();
        int a;
        div = 16'd4;
        goto(cyc + 1);
        a = cyc;
        push_ticks(a, 4, 4);
        push_ticks(a + 16, 6, 4);
        en = 1'b1;
        goto(a + 3);
        div = 16'd6;
        goto(a + 20);
        en = 1'b0;
        goto(a + 41);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL divchg_busy got %0b expected 0", busy); end
        goto(a + 46);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL divchg_pending got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_stretch();
        int a;
        exp_t e;
        div = 16'd5;
        goto(cyc + 1);
        a = cyc;
        e.cyc = a + 5;  e.ph = 2'd0; e.bd = 1'b0; sb.push_back(e);
        e.cyc = a + 10; e.ph = 2'd1; e.bd = 1'b0; sb.push_back(e);
        e.cyc = a + 33; e.ph = 2'd2; e.bd = 1'b0; sb.push_back(e);
        e.cyc = a + 38; e.ph = 2'd3; e.bd = 1'b1; sb.push_back(e);
        en = 1'b1;
        goto(a + 1);
        en = 1'b0;
        goto(a + 11);
        hold = 1'b1;
        goto(a + 15);
        checks++;
        if (q_tick !== 1'b0) begin errors++; $display("FAIL stretch_suppress got %0b expected 0", q_tick); end
        goto(a + 16);
        checks += 3;
        if (stretch !== 1'b1) begin errors++; $display("FAIL stretch_enter got %0b expected 1", stretch); end
        if (phase !== 2'd2)   begin errors++; $display("FAIL stretch_phase got %0d expected 2", phase); end
        if (scl_oe !== 1'b0)  begin errors++; $display("FAIL stretch_scl_oe got %0b expected 0", scl_oe); end
        goto(a + 31);
        hold = 1'b0;
        goto(a + 32);
        checks++;
        if (stretch !== 1'b1) begin errors++; $display("FAIL stretch_hold got %0b expected 1", stretch); end
        goto(a + 34);
        checks += 2;
        if (stretch !== 1'b0) begin errors++; $display("FAIL stretch_exit got %0b expected 0", stretch); end
        if (phase !== 2'd3)   begin errors++; $display("FAIL stretch_resume_phase got %0d expected 3", phase); end
        goto(a + 39);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stretch_idle got %0b expected 0", busy); end
        goto(a + 45);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL stretch_pending got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid();
        int a;
        int b;
        exp_t e;
        div = 16'd8;
        goto(cyc + 1);
        a = cyc;
        e.cyc = a + 8; e.ph = 2'd0; e.bd = 1'b0; sb.push_back(e);
        en = 1'b1;
        goto(a + 12);
        rst = 1'b1;
        en  = 1'b0;
        goto(a + 13);
        checks += 4;
        if (scl_oe !== 1'b0)   begin errors++; $display("FAIL rstmid_scl_oe got %0b expected 0", scl_oe); end
        if (phase !== 2'd0)    begin errors++; $display("FAIL rstmid_phase got %0d expected 0", phase); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got %0b expected 0", busy); end
        if (bit_done !== 1'b0) begin errors++; $display("FAIL rstmid_bit_done got %0b expected 0", bit_done); end
        rst = 1'b0;
        goto(a + 20);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL rstmid_pending got %0d expected 0", sb.size()); sb.delete(); end
        b = cyc;
        push_ticks(b, 8, 4);
        en = 1'b1;
        goto(b + 1);
        en = 1'b0;
        checks += 2;
        if (phase !== 2'd0)  begin errors++; $display("FAIL restart_phase got %0d expected 0", phase); end
        if (scl_oe !== 1'b1) begin errors++; $display("FAIL restart_scl_oe got %0b expected 1", scl_oe); end
        goto(b + 33);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle got %0b expected 0", busy); end
        goto(b + 36);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL restart_pending got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_timeout();
        int a;
        int to_cnt;
        exp_t e;
        to_cnt = 0;
        div = 16'd5;
        goto(cyc + 1);
        a = cyc;
        e.cyc = a + 5;  e.ph = 2'd0; e.bd = 1'b0; sb.push_back(e);
        e.cyc = a + 10; e.ph = 2'd1; e.bd = 1'b0; sb.push_back(e);
        en = 1'b1;
        goto(a + 1);
        en = 1'b0;
        goto(a + 11);
        hold = 1'b1;
`ifdef STRETCH_TIMEOUT_EN
        for (int r = 16; r <= 70; r++) begin
            goto(a + r);
            if (timeout === 1'b1) to_cnt++;
            if (r == 65) begin
                checks++;
                if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %0b expected 1", timeout); end
            end
        end
        checks += 3;
        if (to_cnt !== 1)     begin errors++; $display("FAIL timeout_count got %0d expected 1", to_cnt); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL timeout_idle got %0b expected 0", busy); end
        if (stretch !== 1'b0) begin errors++; $display("FAIL timeout_stretch got %0b expected 0", stretch); end
        hold = 1'b0;
        goto(a + 80);
`else
        for (int r = 16; r <= 100; r++) begin
            goto(a + r);
            if (timeout === 1'b1) to_cnt++;
        end
        checks += 2;
        if (to_cnt !== 0)     begin errors++; $display("FAIL notimeout_count got %0d expected 0", to_cnt); end
        if (stretch !== 1'b1) begin errors++; $display("FAIL notimeout_stretch got %0b expected 1", stretch); end
        e.cyc = a + 103; e.ph = 2'd2; e.bd = 1'b0; sb.push_back(e);
        e.cyc = a + 108; e.ph = 2'd3; e.bd = 1'b1; sb.push_back(e);
        goto(a + 101);
        hold = 1'b0;
        goto(a + 109);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL notimeout_idle got %0b expected 0", busy); end
        goto(a + 115);
`endif
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL timeout_pending got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_basic_and_stop();
        test_clamp();
        test_div_change();
        test_stretch();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
